resp_order_queue: RTL and testbench
===================================

Name: resp_order_queue

Overview:
Parametrised write-response ordering FIFO for the AXI4 interconnect. It records which master, and which transaction ID, owns each granted write so that B-channel responses are routed back in issue order. Depth, master count and transaction-ID width are generic. Compared with the single-entry response queue, it adds occupancy count, almost-full, flush, simultaneous push/pop and error reporting. One instance sits per slave port, between the AW arbiter (push) and the B-channel router (pop).

Parameters:
Masters_Num, 4, number of masters; must be 2 or more
ID_Size, $clog2(Masters_Num), width of the master ID field
Txn_ID_Width, 4, width of the AXI AWID stored with each entry
Depth, 8, number of queue entries; must be a power of 2 and 2 or more
Almost_Full_Thresh, Depth-1, occupancy at or above which Queue_Almost_Full asserts

Ports:
ACLK  in  1  clock, all state updates on the rising edge
ARESETN  in  1  asynchronous active-low reset
Master_ID  in  ID_Size  master owning the granted write
Txn_ID  in  Txn_ID_Width  AWID of the granted write
Write_Resp_Grant  in  1  push request, sampled on the rising edge
Write_Resp_Finsh  in  1  pop request: head response completed (BVALID&&BREADY)
Queue_Flush  in  1  synchronous clear
Resp_Master_ID  out  ID_Size  master ID at the head entry
Resp_Txn_ID  out  Txn_ID_Width  transaction ID at the head entry
Resp_Master_Valid  out  1  queue is non-empty, so the head is valid
Queue_Is_Full  out  1  count == Depth
Queue_Almost_Full  out  1  count >= Almost_Full_Thresh
Queue_Count  out  $clog2(Depth)+1  current occupancy
Overflow_Err  out  1  one-cycle pulse: a push was rejected
Underflow_Err  out  1  one-cycle pulse: a pop was rejected

Behaviour:
- Storage: Depth x (ID_Size+Txn_ID_Width) register array; write pointer, read pointer and count registers.
  - Pointers are $clog2(Depth) bits wide and wrap naturally from Depth-1 to 0.
- Reset (ARESETN=0, asynchronous): pointers=0, count=0, Overflow_Err=0, Underflow_Err=0.
  - Resulting outputs: Resp_Master_Valid=0, Queue_Is_Full=0, Queue_Almost_Full=0 (if Thresh>0), Queue_Count=0.
  - Resp_Master_ID and Resp_Txn_ID read 0 after reset. Storage contents need not be reset, but the head outputs are forced to 0 while empty.
- Output path: Resp_Master_ID and Resp_Txn_ID are combinational reads of the entry at the read pointer, gated to 0 when empty.
  - All flags are decoded from the count register, so they are glitch-free relative to ACLK.
- Push accept: Write_Resp_Grant && (!full || pop_accept).
  - On accept, the entry is written at the write pointer and the write pointer increments.
- Pop accept: Write_Resp_Finsh && !empty. On accept, the read pointer increments.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Latency: a push on edge N into an empty queue gives Resp_Master_Valid=1 with the new IDs after edge N. There is no bypass; the same-cycle head is not visible.
- Simultaneous push and pop:
  - When full: both accepted, count stays Depth, Queue_Is_Full stays 1.
  - When empty: push accepted, pop rejected, Underflow_Err pulses, count becomes 1.
- Rejections: a push while full with no pop sets Overflow_Err=1 for exactly the next cycle; queue state is unchanged.
  - A pop while empty sets Underflow_Err=1 for exactly the next cycle.
- Queue_Flush=1:
  - Takes effect on the next edge: pointers=0, count=0.
  - Overrides push and pop in the same cycle; neither is accepted and no error pulses are generated.
- Reset mid-operation: all entries are discarded immediately and no error pulse is generated.
  - Pushes are accepted on the first rising edge after ARESETN deasserts.
- Width rule: Queue_Count must represent Depth exactly, hence $clog2(Depth)+1 bits.

Test Plan:
1. After reset, push (Master_ID=2, Txn_ID=5), wait 1 cycle -> Resp_Master_Valid=1, Resp_Master_ID=2, Resp_Txn_ID=5, Queue_Count=1. Then pop -> Resp_Master_Valid=0, Queue_Count=0, head outputs 0.
2. Depth=8: push IDs 0,1,2,3,0,1,2,3 with Txn 0..7 -> Queue_Almost_Full=1 at count 7, Queue_Is_Full=1 at count 8. Ninth push -> Overflow_Err pulses 1 cycle, count stays 8. Eight pops return masters 0,1,2,3,0,1,2,3 in order.
3. With the queue full, push (3,9) and pop in the same cycle -> count stays 8, no Overflow_Err. After 7 further pops the head is (3,9), proving pointer wrap.
4. On an empty queue, push (1,4) and pop in the same cycle -> count=1, head=(1,4), Underflow_Err pulses once. A lone pop on an empty queue also gives an Underflow_Err pulse and count stays 0.
5. With count=5, assert Queue_Flush together with a push -> count=0, Resp_Master_Valid=0, no error pulses. A subsequent push (2,1) appears at the head after 1 cycle.
6. With count=3, drop ARESETN asynchronously between edges -> outputs go to reset values immediately. After release, push (1,2) -> head=(1,2), count=1.

Source files
------------

// File: rtl/resp_order_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : resp_order_queue_if
//  Description : Push/pop and status bundle for the write-response ordering
//                queue. The master side is the AW arbiter / B-channel router
//                pair; the slave side is the queue itself.
//                Push : Master_ID, Txn_ID, Write_Resp_Grant
//                Pop  : Write_Resp_Finsh
//                Ctrl : Queue_Flush
//                Head : Resp_Master_ID, Resp_Txn_ID, Resp_Master_Valid
//                Stat : Queue_Is_Full, Queue_Almost_Full, Queue_Count,
//                       Overflow_Err, Underflow_Err
//  Revision    : 1.0 - initial release
// ============================================================================
interface resp_order_queue_if #(
    parameter int Masters_Num  = 4,
    parameter int ID_Size      = $clog2(Masters_Num),
    parameter int Txn_ID_Width = 4,
    parameter int Depth        = 8
);
    logic [ID_Size-1:0]        Master_ID;
    logic [Txn_ID_Width-1:0]   Txn_ID;
    logic                      Write_Resp_Grant;
    logic                      Write_Resp_Finsh;
    logic                      Queue_Flush;
    logic [ID_Size-1:0]        Resp_Master_ID;
    logic [Txn_ID_Width-1:0]   Resp_Txn_ID;
    logic                      Resp_Master_Valid;
    logic                      Queue_Is_Full;
    logic                      Queue_Almost_Full;
    logic [$clog2(Depth):0]    Queue_Count;
    logic                      Overflow_Err;
    logic                      Underflow_Err;

    modport master (
        output Master_ID, Txn_ID, Write_Resp_Grant, Write_Resp_Finsh, Queue_Flush,
        input  Resp_Master_ID, Resp_Txn_ID, Resp_Master_Valid, Queue_Is_Full,
               Queue_Almost_Full, Queue_Count, Overflow_Err, Underflow_Err
    );

    modport slave (
        input  Master_ID, Txn_ID, Write_Resp_Grant, Write_Resp_Finsh, Queue_Flush,
        output Resp_Master_ID, Resp_Txn_ID, Resp_Master_Valid, Queue_Is_Full,
               Queue_Almost_Full, Queue_Count, Overflow_Err, Underflow_Err
    );
endinterface
`default_nettype wire

// File: rtl/resp_order_queue.sv
`default_nettype none
// ============================================================================
//  Module      : resp_order_queue
//  Description : Write-response ordering FIFO. Records the owning master and
//                AWID of each granted write so B responses are routed back in
//                issue order. Supports simultaneous push/pop, flush, occupancy
//                count, almost-full and one-cycle overflow/underflow pulses.
//  Ports       : ACLK     - clock, rising edge
//                ARESETN  - asynchronous active-low reset
//                bus      - resp_order_queue_if.slave (push, pop, flush,
//                           head entry and status flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_order_queue #(
    parameter int Masters_Num        = 4,
    parameter int ID_Size            = $clog2(Masters_Num),
    parameter int Txn_ID_Width       = 4,
    parameter int Depth              = 8,
    parameter int Almost_Full_Thresh = Depth - 1
) (
    input  wire logic             ACLK,
    input  wire logic             ARESETN,
    resp_order_queue_if.slave     bus
);
    localparam int c_PTR_W   = $clog2(Depth);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = ID_Size + Txn_ID_Width;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(Depth);
    localparam logic [c_CNT_W-1:0] c_AF      = c_CNT_W'(Almost_Full_Thresh);

    logic [c_ENTRY_W-1:0] r_mem [Depth];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_acc;
    logic                 w_push_acc;
    logic                 w_overflow;
    logic                 w_underflow;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    // Flush wins over both requests and also suppresses the error pulses.
    assign w_pop_acc  = bus.Write_Resp_Finsh && !w_empty && !bus.Queue_Flush;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push_acc = bus.Write_Resp_Grant && (!w_full || w_pop_acc) && !bus.Queue_Flush;

    assign w_overflow  = bus.Write_Resp_Grant && w_full && !w_pop_acc && !bus.Queue_Flush;
    assign w_underflow = bus.Write_Resp_Finsh && w_empty && !bus.Queue_Flush;

    // Storage is not reset; the head outputs are masked while empty instead.
    always_ff @(posedge ACLK) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= {bus.Master_ID, bus.Txn_ID};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;
            if (bus.Queue_Flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_acc) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop_acc) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                case ({w_push_acc, w_pop_acc})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.Resp_Master_ID    = w_empty ? '0 : w_head[c_ENTRY_W-1:Txn_ID_Width];
    assign bus.Resp_Txn_ID       = w_empty ? '0 : w_head[Txn_ID_Width-1:0];
    assign bus.Resp_Master_Valid = !w_empty;
    assign bus.Queue_Is_Full     = w_full;
    assign bus.Queue_Almost_Full = (r_count >= c_AF);
    assign bus.Queue_Count       = r_count;
    assign bus.Overflow_Err      = r_overflow;
    assign bus.Underflow_Err     = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_resp_order_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resp_order_queue
//  Description : Directed self-checking bench for resp_order_queue with the
//                default parameters (4 masters, 4-bit AWID, depth 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_order_queue;
    logic ACLK;
    logic ARESETN;
    int   checks;
    int   failures;

    resp_order_queue_if bus_if ();

    resp_order_queue dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus_if)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Drive one cycle of requests, let the edge happen, sample 1 ns later.
    task automatic do_cycle(input logic grant, input int mid, input int tid,
                            input logic finsh, input logic flush);
        bus_if.Write_Resp_Grant = grant;
        bus_if.Master_ID        = 2'(mid);
        bus_if.Txn_ID           = 4'(tid);
        bus_if.Write_Resp_Finsh = finsh;
        bus_if.Queue_Flush      = flush;
        @(posedge ACLK);
        #1;
        bus_if.Write_Resp_Grant = 1'b0;
        bus_if.Write_Resp_Finsh = 1'b0;
        bus_if.Queue_Flush      = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #2;
        checks++; if (bus_if.Resp_Master_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%0d exp=0", bus_if.Resp_Master_Valid); end
        checks++; if (bus_if.Queue_Count !== 4'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", bus_if.Queue_Count); end
        checks++; if (bus_if.Queue_Is_Full !== 1'b0 || bus_if.Queue_Almost_Full !== 1'b0) begin failures++; $display("FAIL reset_flags act=%b%b exp=00", bus_if.Queue_Is_Full, bus_if.Queue_Almost_Full); end
        checks++; if (bus_if.Resp_Master_ID !== 2'd0 || bus_if.Resp_Txn_ID !== 4'd0) begin failures++; $display("FAIL reset_head act=(%0d,%0d) exp=(0,0)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID); end
        checks++; if (bus_if.Overflow_Err !== 1'b0 || bus_if.Underflow_Err !== 1'b0) begin failures++; $display("FAIL reset_err act=%b%b exp=00", bus_if.Overflow_Err, bus_if.Underflow_Err); end
        #10;
        ARESETN = 1'b1;
    endtask

    task automatic test_single();
        do_cycle(1'b1, 2, 5, 1'b0, 1'b0);
        checks++; if (bus_if.Resp_Master_Valid !== 1'b1 || bus_if.Queue_Count !== 4'd1) begin failures++; $display("FAIL single_push act=v%b c%0d exp=v1 c1", bus_if.Resp_Master_Valid, bus_if.Queue_Count); end
        checks++; if (bus_if.Resp_Master_ID !== 2'd2 || bus_if.Resp_Txn_ID !== 4'd5) begin failures++; $display("FAIL single_head act=(%0d,%0d) exp=(2,5)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID); end
        do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
        checks++; if (bus_if.Resp_Master_Valid !== 1'b0 || bus_if.Queue_Count !== 4'd0) begin failures++; $display("FAIL single_pop act=v%b c%0d exp=v0 c0", bus_if.Resp_Master_Valid, bus_if.Queue_Count); end
        checks++; if (bus_if.Resp_Master_ID !== 2'd0 || bus_if.Resp_Txn_ID !== 4'd0) begin failures++; $display("FAIL single_head0 act=(%0d,%0d) exp=(0,0)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, i % 4, i, 1'b0, 1'b0);
            checks++; if (bus_if.Queue_Count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count act=%0d exp=%0d", bus_if.Queue_Count, i + 1); end
            checks++; if (bus_if.Queue_Almost_Full !== (i + 1 >= 7)) begin failures++; $display("FAIL fill_almost act=%b exp=%b", bus_if.Queue_Almost_Full, (i + 1 >= 7)); end
            checks++; if (bus_if.Queue_Is_Full !== (i + 1 == 8)) begin failures++; $display("FAIL fill_full act=%b exp=%b", bus_if.Queue_Is_Full, (i + 1 == 8)); end
        end
        do_cycle(1'b1, 1, 15, 1'b0, 1'b0);
        checks++; if (bus_if.Overflow_Err !== 1'b1 || bus_if.Queue_Count !== 4'd8) begin failures++; $display("FAIL overflow act=e%b c%0d exp=e1 c8", bus_if.Overflow_Err, bus_if.Queue_Count); end
        checks++; if (bus_if.Resp_Master_ID !== 2'd0 || bus_if.Resp_Txn_ID !== 4'd0) begin failures++; $display("FAIL overflow_head act=(%0d,%0d) exp=(0,0)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID); end
        do_cycle(1'b0, 0, 0, 1'b0, 1'b0);
        checks++; if (bus_if.Overflow_Err !== 1'b0) begin failures++; $display("FAIL overflow_pulse act=%b exp=0", bus_if.Overflow_Err); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus_if.Resp_Master_ID !== 2'(i % 4) || bus_if.Resp_Txn_ID !== 4'(i)) begin failures++; $display("FAIL drain_head act=(%0d,%0d) exp=(%0d,%0d)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID, i % 4, i); end
            do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
        end
        checks++; if (bus_if.Queue_Count !== 4'd0 || bus_if.Underflow_Err !== 1'b0) begin failures++; $display("FAIL drain_end act=c%0d u%b exp=c0 u0", bus_if.Queue_Count, bus_if.Underflow_Err); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) do_cycle(1'b1, i % 4, i, 1'b0, 1'b0);
        do_cycle(1'b1, 3, 9, 1'b1, 1'b0);
        checks++; if (bus_if.Queue_Count !== 4'd8 || bus_if.Queue_Is_Full !== 1'b1) begin failures++; $display("FAIL fullpp_count act=c%0d f%b exp=c8 f1", bus_if.Queue_Count, bus_if.Queue_Is_Full); end
        checks++; if (bus_if.Overflow_Err !== 1'b0) begin failures++; $display("FAIL fullpp_ovf act=%b exp=0", bus_if.Overflow_Err); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (bus_if.Resp_Master_ID !== 2'(i % 4) || bus_if.Resp_Txn_ID !== 4'(i)) begin failures++; $display("FAIL fullpp_head act=(%0d,%0d) exp=(%0d,%0d)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID, i % 4, i); end
            do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
        end
        checks++; if (bus_if.Resp_Master_ID !== 2'd3 || bus_if.Resp_Txn_ID !== 4'd9 || bus_if.Queue_Count !== 4'd1) begin failures++; $display("FAIL wrap_head act=(%0d,%0d) c%0d exp=(3,9) c1", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID, bus_if.Queue_Count); end
        do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_empty_push_pop();
        do_cycle(1'b1, 1, 4, 1'b1, 1'b0);
        checks++; if (bus_if.Queue_Count !== 4'd1 || bus_if.Underflow_Err !== 1'b1) begin failures++; $display("FAIL emptypp act=c%0d u%b exp=c1 u1", bus_if.Queue_Count, bus_if.Underflow_Err); end
        checks++; if (bus_if.Resp_Master_ID !== 2'd1 || bus_if.Resp_Txn_ID !== 4'd4) begin failures++; $display("FAIL emptypp_head act=(%0d,%0d) exp=(1,4)", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID); end
        do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
        checks++; if (bus_if.Underflow_Err !== 1'b0 || bus_if.Queue_Count !== 4'd0) begin failures++; $display("FAIL emptypp_pulse act=u%b c%0d exp=u0 c0", bus_if.Underflow_Err, bus_if.Queue_Count); end
        do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
        checks++; if (bus_if.Underflow_Err !== 1'b1 || bus_if.Queue_Count !== 4'd0) begin failures++; $display("FAIL underflow act=u%b c%0d exp=u1 c0", bus_if.Underflow_Err, bus_if.Queue_Count); end
        do_cycle(1'b0, 0, 0, 1'b0, 1'b0);
        checks++; if (bus_if.Underflow_Err !== 1'b0) begin failures++; $display("FAIL underflow_pulse act=%b exp=0", bus_if.Underflow_Err); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 3, i + 10, 1'b0, 1'b0);
        checks++; if (bus_if.Queue_Count !== 4'd5) begin failures++; $display("FAIL preflush_count act=%0d exp=5", bus_if.Queue_Count); end
        do_cycle(1'b1, 1, 7, 1'b1, 1'b1);
        checks++; if (bus_if.Queue_Count !== 4'd0 || bus_if.Resp_Master_Valid !== 1'b0) begin failures++; $display("FAIL flush act=c%0d v%b exp=c0 v0", bus_if.Queue_Count, bus_if.Resp_Master_Valid); end
        checks++; if (bus_if.Overflow_Err !== 1'b0 || bus_if.Underflow_Err !== 1'b0) begin failures++; $display("FAIL flush_err act=%b%b exp=00", bus_if.Overflow_Err, bus_if.Underflow_Err); end
        do_cycle(1'b0, 0, 0, 1'b1, 1'b1);
        checks++; if (bus_if.Underflow_Err !== 1'b0 || bus_if.Queue_Count !== 4'd0) begin failures++; $display("FAIL flush_empty act=u%b c%0d exp=u0 c0", bus_if.Underflow_Err, bus_if.Queue_Count); end
        do_cycle(1'b1, 2, 1, 1'b0, 1'b0);
        checks++; if (bus_if.Resp_Master_ID !== 2'd2 || bus_if.Resp_Txn_ID !== 4'd1 || bus_if.Queue_Count !== 4'd1) begin failures++; $display("FAIL postflush act=(%0d,%0d) c%0d exp=(2,1) c1", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID, bus_if.Queue_Count); end
        do_cycle(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b1, i, i + 3, 1'b0, 1'b0);
        checks++; if (bus_if.Queue_Count !== 4'd3) begin failures++; $display("FAIL prereset_count act=%0d exp=3", bus_if.Queue_Count); end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++; if (bus_if.Queue_Count !== 4'd0 || bus_if.Resp_Master_Valid !== 1'b0) begin failures++; $display("FAIL async_reset act=c%0d v%b exp=c0 v0", bus_if.Queue_Count, bus_if.Resp_Master_Valid); end
        checks++; if (bus_if.Resp_Master_ID !== 2'd0 || bus_if.Resp_Txn_ID !== 4'd0 || bus_if.Overflow_Err !== 1'b0 || bus_if.Underflow_Err !== 1'b0) begin failures++; $display("FAIL async_reset_out act=(%0d,%0d) e%b%b exp=(0,0) e00", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID, bus_if.Overflow_Err, bus_if.Underflow_Err); end
        #2;
        ARESETN = 1'b1;
        do_cycle(1'b1, 1, 2, 1'b0, 1'b0);
        checks++; if (bus_if.Resp_Master_ID !== 2'd1 || bus_if.Resp_Txn_ID !== 4'd2 || bus_if.Queue_Count !== 4'd1) begin failures++; $display("FAIL post_reset act=(%0d,%0d) c%0d exp=(1,2) c1", bus_if.Resp_Master_ID, bus_if.Resp_Txn_ID, bus_if.Queue_Count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus_if.Master_ID        = '0;
        bus_if.Txn_ID           = '0;
        bus_if.Write_Resp_Grant = 1'b0;
        bus_if.Write_Resp_Finsh = 1'b0;
        bus_if.Queue_Flush      = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
